// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS32 control FSM and its datapath.
// master: controller (drives strobes/selects), slave: datapath/memory side.
interface multi_cycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_write, i_or_d, ir_write,
        output pc_write, pc_src, alu_src_a, alu_src_b,
        output alu_control, reg_dst, mem_to_reg,
        output reg_write, state, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_write, i_or_d, ir_write,
        input  pc_write, pc_src, alu_src_a, alu_src_b,
        input  alu_control, reg_dst, mem_to_reg,
        input  reg_write, state, illegal
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for a shared-memory multi-cycle MIPS32 datapath.
// Ports: CLK, RST (sync, active-high), bus (multi_cycle_ctrl_if.master:
//   op/funct/zero/mem_ready in; memory, PC, ALU, regfile controls,
//   state and sticky illegal out).
// Optional MC_PERF_CNT_EN adds cycle_cnt/instret_cnt (CNT_W bits).
module multi_cycle_ctrl
`ifdef MC_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic CLK,
    input  logic RST,
    multi_cycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state_q;
    state_t nxt;
    ctl_t   ctl_q;
    logic   illegal_q;

    function automatic logic legal_funct(input logic [5:0] f);
        return (f == F_ADD) || (f == F_SUB) || (f == F_AND)
            || (f == F_OR) || (f == F_SLT);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        logic [2:0] a;
        case (f)
            F_SUB:   a = 3'b110;
            F_AND:   a = 3'b000;
            F_OR:    a = 3'b001;
            F_SLT:   a = 3'b111;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Moore outputs of the state being entered, so they come out of flops.
    function automatic ctl_t ctl_of(input state_t s,
                                    input logic [5:0] f);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req     = 1'b1;
                c.alu_src_b   = 2'b01;
                c.alu_control = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b   = 2'b11;
                c.alu_control = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b10;
                c.alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = alu_of(f);
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_SUB;
                c.pc_src      = 2'b01;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP:   c.pc_src    = 2'b10;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = S_FETCH;
        case (state_q)
            S_FETCH:
                nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    OP_R:
                        nxt = legal_funct(bus.funct) ? S_EXEC : S_TRAP;
                    default:      nxt = S_TRAP;
                endcase
            end
            S_MEMADR:
                nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:
                nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:
                nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            ctl_q     <= ctl_of(S_FETCH, bus.funct);
        end else begin
            state_q   <= nxt;
            illegal_q <= illegal_q | (nxt == S_TRAP);
            ctl_q     <= ctl_of(nxt, bus.funct);
        end
    end

    // Strobes are killed combinationally in the RST cycle so an
    // in-flight access never commits a write.
    assign bus.mem_req   = ctl_q.mem_req & ~RST;
    assign bus.mem_write = ctl_q.mem_write & ~RST;
    assign bus.reg_write = ctl_q.reg_write & ~RST;
    assign bus.ir_write  = ~RST & (state_q == S_FETCH)
                         & bus.mem_ready;
    assign bus.pc_write  = ~RST & (
                           ((state_q == S_FETCH) & bus.mem_ready)
                         | ((state_q == S_BRANCH) & bus.zero)
                         | (state_q == S_JUMP));

    assign bus.i_or_d      = ctl_q.i_or_d;
    assign bus.pc_src      = ctl_q.pc_src;
    assign bus.alu_src_a   = ctl_q.alu_src_a;
    assign bus.alu_src_b   = ctl_q.alu_src_b;
    assign bus.alu_control = ctl_q.alu_control;
    assign bus.reg_dst     = ctl_q.reg_dst;
    assign bus.mem_to_reg  = ctl_q.mem_to_reg;
    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic retire;

    // An instruction retires on the cycle that leaves for FETCH.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: retire = 1'b1;
            S_MEMWR:          retire = bus.mem_ready;
            default:          retire = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state_q != S_TRAP)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire)
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Testbench for multi_cycle_ctrl: scripted instruction streams, expected
// per-cycle controls queued as each cycle is driven and checked on output.
module tb_multi_cycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    // strb = {mem_req, mem_write, i_or_d, ir_write, pc_write, reg_write}
    // side = {reg_dst, mem_to_reg, pc_src}, src = {alu_src_a, alu_src_b}
    typedef struct packed {
        logic [3:0] st;
        logic [5:0] strb;
        logic [2:0] alu;
        logic [3:0] side;
        logic [2:0] src;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] op;
        logic [5:0] funct;
        logic       rdy;
        logic       z;
    } stim_t;

    logic CLK;
    logic RST;
    multi_cycle_ctrl_if bus();

    stim_t plan[$];
    exp_t  sb[$];
    int    passed;
    int    total;

`ifdef MC_PERF_CNT_EN
    logic [3:0] cycle_cnt;
    logic [3:0] instret_cnt;
    multi_cycle_ctrl #(.CNT_W(4)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );
`else
    multi_cycle_ctrl dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected controls for one cycle in state st, from the state table.
    function automatic exp_t mk(input logic [3:0] st, input logic r,
                                input logic z, input logic [5:0] f);
        exp_t e;
        e = '0;
        e.st  = st;
        e.ill = (st == 4'd15);
        case (st)
            4'd0: begin
                e.strb = {1'b1, 1'b0, 1'b0, r, r, 1'b0};
                e.alu  = 3'b010;
                e.src  = 3'b001;
            end
            4'd1: begin e.alu = 3'b010; e.src = 3'b011; end
            4'd2: begin e.alu = 3'b010; e.src = 3'b110; end
            4'd3: e.strb = 6'b101000;
            4'd4: begin e.strb = 6'b000001; e.side = 4'b0100; end
            4'd5: e.strb = 6'b111000;
            4'd6: begin
                e.src = 3'b100;
                case (f)
                    F_ADD:   e.alu = 3'b010;
                    F_SUB:   e.alu = 3'b110;
                    F_AND:   e.alu = 3'b000;
                    F_OR:    e.alu = 3'b001;
                    default: e.alu = 3'b111;
                endcase
            end
            4'd7: begin e.strb = 6'b000001; e.side = 4'b1000; end
            4'd8: begin
                e.strb = {4'b0000, z, 1'b0};
                e.alu  = 3'b110;
                e.side = 4'b0001;
                e.src  = 3'b100;
            end
            4'd9:  begin e.alu = 3'b010; e.src = 3'b110; end
            4'd10: e.strb = 6'b000001;
            4'd11: begin e.strb = 6'b000010; e.side = 4'b0010; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.st   = bus.state;
        o.strb = {bus.mem_req, bus.mem_write, bus.i_or_d,
                  bus.ir_write, bus.pc_write, bus.reg_write};
        o.alu  = bus.alu_control;
        o.side = {bus.reg_dst, bus.mem_to_reg, bus.pc_src};
        o.src  = {bus.alu_src_a, bus.alu_src_b};
        o.ill  = bus.illegal;
        return o;
    endfunction

    task automatic p(input logic [3:0] st, input logic [5:0] op,
                     input logic [5:0] f, input logic r,
                     input logic z);
        plan.push_back({st, op, f, r, z});
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        bus.op = OP_R;
        bus.funct = F_ADD;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        total++;
        if (bus.state !== 4'd0)
            $display("FAIL reset_state: got %0d want 0", bus.state);
        else passed++;
        total++;
        if (bus.illegal !== 1'b0)
            $display("FAIL reset_illegal: got %b want 0", bus.illegal);
        else passed++;
        total++;
        if ({bus.mem_req, bus.mem_write, bus.ir_write,
             bus.pc_write, bus.reg_write} !== 5'b0)
            $display("FAIL reset_strobes: got %b want 00000",
                     {bus.mem_req, bus.mem_write, bus.ir_write,
                      bus.pc_write, bus.reg_write});
        else passed++;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] fs [5];
        stim_t s;
        exp_t  e, o;
        int    n;
        fs = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
        foreach (fs[i]) begin
            p(4'd0, OP_R, fs[i], 1'b1, 1'b0);
            p(4'd1, OP_R, fs[i], 1'b1, 1'b0);
            p(4'd6, OP_R, fs[i], 1'b1, 1'b0);
            p(4'd7, OP_R, fs[i], 1'b1, 1'b0);
        end
        n = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.op = s.op; bus.funct = s.funct;
            bus.mem_ready = s.rdy; bus.zero = s.z;
            sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
            #1;
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e)
                $display("FAIL rtype cyc%0d: got %h want %h", n, o, e);
            else passed++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_lw_wait();
        stim_t s;
        exp_t  e, o;
        int    n;
        p(4'd0, OP_LW, 6'h00, 1'b1, 1'b0);
        p(4'd1, OP_LW, 6'h00, 1'b0, 1'b0);
        p(4'd2, OP_LW, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            p(4'd3, OP_LW, 6'h00, 1'b0, 1'b0);
        p(4'd3, OP_LW, 6'h00, 1'b1, 1'b0);
        p(4'd4, OP_LW, 6'h00, 1'b1, 1'b0);
        n = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.op = s.op; bus.funct = s.funct;
            bus.mem_ready = s.rdy; bus.zero = s.z;
            sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
            #1;
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e)
                $display("FAIL lw_wait cyc%0d: got %h want %h", n, o, e);
            else passed++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_beq();
        stim_t s;
        exp_t  e, o;
        int    n;
        for (int z = 1; z >= 0; z--) begin
            p(4'd0, OP_BEQ, 6'h00, 1'b1, 1'(z));
            p(4'd1, OP_BEQ, 6'h00, 1'b1, 1'(z));
            p(4'd8, OP_BEQ, 6'h00, 1'b1, 1'(z));
        end
        n = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.op = s.op; bus.funct = s.funct;
            bus.mem_ready = s.rdy; bus.zero = s.z;
            sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
            #1;
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e)
                $display("FAIL beq cyc%0d: got %h want %h", n, o, e);
            else passed++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e, o;
        int    n;
        p(4'd0, OP_R, F_ADD, 1'b0, 1'b0);
        p(4'd0, OP_R, F_ADD, 1'b0, 1'b0);
        p(4'd0, OP_R, F_ADD, 1'b1, 1'b0);
        p(4'd1, OP_R, F_ADD, 1'b1, 1'b0);
        p(4'd6, OP_R, F_ADD, 1'b1, 1'b0);
        p(4'd7, OP_R, F_ADD, 1'b1, 1'b0);
        p(4'd0, OP_SW, 6'h00, 1'b1, 1'b0);
        p(4'd1, OP_SW, 6'h00, 1'b1, 1'b0);
        p(4'd2, OP_SW, 6'h00, 1'b1, 1'b0);
        p(4'd5, OP_SW, 6'h00, 1'b1, 1'b0);
        p(4'd0, OP_ADDI, 6'h00, 1'b1, 1'b0);
        p(4'd1, OP_ADDI, 6'h00, 1'b1, 1'b0);
        p(4'd9, OP_ADDI, 6'h00, 1'b1, 1'b0);
        p(4'd10, OP_ADDI, 6'h00, 1'b1, 1'b0);
        p(4'd0, OP_J, 6'h00, 1'b1, 1'b0);
        p(4'd1, OP_J, 6'h00, 1'b1, 1'b0);
        p(4'd11, OP_J, 6'h00, 1'b1, 1'b0);
        p(4'd0, OP_R, F_ADD, 1'b0, 1'b0);
        n = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.op = s.op; bus.funct = s.funct;
            bus.mem_ready = s.rdy; bus.zero = s.z;
            sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
            #1;
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e)
                $display("FAIL b2b cyc%0d: got %h want %h", n, o, e);
            else passed++;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_access();
        stim_t s;
        exp_t  e, o;
        int    n;
        p(4'd0, OP_SW, 6'h00, 1'b1, 1'b0);
        p(4'd1, OP_SW, 6'h00, 1'b0, 1'b0);
        p(4'd2, OP_SW, 6'h00, 1'b0, 1'b0);
        p(4'd5, OP_SW, 6'h00, 1'b0, 1'b0);
        p(4'd5, OP_SW, 6'h00, 1'b0, 1'b0);
        n = 0;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            bus.op = s.op; bus.funct = s.funct;
            bus.mem_ready = s.rdy; bus.zero = s.z;
            sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
            #1;
            e = sb.pop_front();
            o = observe();
            total++;
            if (o !== e)
                $display("FAIL rst_mid cyc%0d: got %h want %h", n, o, e);
            else passed++;
            n++;
            @(negedge CLK);
        end
        RST = 1'b1;
        #1;
        total++;
        if ({bus.mem_req, bus.mem_write} !== 2'b00)
            $display("FAIL rst_mid_strobes: got %b want 00",
                     {bus.mem_req, bus.mem_write});
        else passed++;
        @(negedge CLK);
        #1;
        total++;
        if (bus.state !== 4'd0)
            $display("FAIL rst_mid_state: got %0d want 0", bus.state);
        else passed++;
        RST = 1'b0;
    endtask

    task automatic test_trap();
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        stim_t s;
        exp_t  e, o;
        int    n;
        ops = '{6'b111111, OP_R};
        fns = '{F_ADD, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            p(4'd0, ops[k], fns[k], 1'b1, 1'b0);
            p(4'd1, ops[k], fns[k], 1'b1, 1'b0);
            for (int i = 0; i < 12; i++)
                p(4'd15, ops[k], fns[k], 1'b1, 1'b1);
            n = 0;
            while (plan.size() > 0) begin
                s = plan.pop_front();
                bus.op = s.op; bus.funct = s.funct;
                bus.mem_ready = s.rdy; bus.zero = s.z;
                sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
                #1;
                e = sb.pop_front();
                o = observe();
                total++;
                if (o !== e)
                    $display("FAIL trap%0d cyc%0d: got %h want %h",
                             k, n, o, e);
                else passed++;
                n++;
                @(negedge CLK);
            end
            RST = 1'b1;
            bus.mem_ready = 1'b0;
            @(negedge CLK);
            #1;
            total++;
            if ({bus.state, bus.illegal} !== 5'b0000_0)
                $display("FAIL trap%0d_reset: got st=%0d ill=%b want 0/0",
                         k, bus.state, bus.illegal);
            else passed++;
            RST = 1'b0;
        end
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        stim_t s;
        exp_t  e, o;
        test_reset();
        for (int r = 0; r < 2; r++) begin
            p(4'd0, OP_R, F_ADD, 1'b1, 1'b0);
            p(4'd1, OP_R, F_ADD, 1'b1, 1'b0);
            p(4'd6, OP_R, F_ADD, 1'b1, 1'b0);
            p(4'd7, OP_R, F_ADD, 1'b1, 1'b0);
            if (r == 0) begin
                p(4'd0, OP_SW, 6'h00, 1'b1, 1'b0);
                p(4'd1, OP_SW, 6'h00, 1'b1, 1'b0);
                p(4'd2, OP_SW, 6'h00, 1'b1, 1'b0);
                p(4'd5, OP_SW, 6'h00, 1'b1, 1'b0);
                p(4'd0, OP_J, 6'h00, 1'b1, 1'b0);
                p(4'd1, OP_J, 6'h00, 1'b1, 1'b0);
                p(4'd11, OP_J, 6'h00, 1'b1, 1'b0);
            end else begin
                p(4'd0, OP_R, F_ADD, 1'b0, 1'b0);
            end
            while (plan.size() > 0) begin
                s = plan.pop_front();
                bus.op = s.op; bus.funct = s.funct;
                bus.mem_ready = s.rdy; bus.zero = s.z;
                sb.push_back(mk(s.st, s.rdy, s.z, s.funct));
                #1;
                e = sb.pop_front();
                o = observe();
                total++;
                if (o !== e)
                    $display("FAIL perf_seq: got %h want %h", o, e);
                else passed++;
                @(negedge CLK);
            end
            bus.mem_ready = 1'b0;
            #1;
            total++;
            if (cycle_cnt !== ((r == 0) ? 4'd11 : 4'd0))
                $display("FAIL perf_cycle%0d: got %0d want %0d", r,
                         cycle_cnt, (r == 0) ? 11 : 0);
            else passed++;
            total++;
            if (instret_cnt !== ((r == 0) ? 4'd3 : 4'd4))
                $display("FAIL perf_instret%0d: got %0d want %0d", r,
                         instret_cnt, (r == 0) ? 3 : 4);
            else passed++;
        end
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_reset_mid_access();
        test_trap();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
